// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and wait-counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dmem_state_t;

  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-port bus between the control unit (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);

  logic              data_cyc_i;
  logic              data_stb_i;
  logic              data_we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  logic              data_ack_o;
  logic              int_req_o;
  logic              int_ack_i;

  modport master (
    output data_cyc_i, data_stb_i, data_we_i, addr_i, data_i, int_ack_i,
    input  data_o, data_ack_o, int_req_o
  );

  modport slave (
    input  data_cyc_i, data_stb_i, data_we_i, addr_i, data_i, int_ack_i,
    output data_o, data_ack_o, int_req_o
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port data RAM: synchronous write, synchronous read, shared address. Contents are not reset.
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[idx] <= wdata;
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Wishbone-style data-bus responder with programmable wait states and a registered one-cycle ack.
// Define DMEM_MAILBOX_INT_EN to raise int_req_o on a completed write to MBOX_ADDR.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DEPTH     = 256,
  parameter int unsigned       WAIT_CYC  = 1,
  parameter logic [ADDR_W-1:0] MBOX_ADDR = ADDR_W'(8'hFF)
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dmem_state_t             state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    ack_q, ack_d;
  logic                    zero_q, zero_d;
  logic                    int_req_q, int_req_d;

  logic                    req_c;
  logic                    enter_ack_c;
  logic                    in_range_c;
  logic                    mem_en_c;
  logic [ADDR_W-1:0]       cur_addr_c;
  logic                    cur_we_c;
  logic [DATA_W-1:0]       cur_wdata_c;
  logic [DATA_W-1:0]       rdata_c;

  // Next-state, request latching and transfer-side effects
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    req_c   = bus.data_cyc_i & bus.data_stb_i;

    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          addr_d  = bus.addr_i;
          we_d    = bus.data_we_i;
          wdata_d = bus.data_i;
          if (WAIT_CYC == 0) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_CNT_W'(WAIT_CYC - 1);
          end
        end
      end
      WAIT: begin
        if (!bus.data_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // With zero wait states the RAM is accessed on the same edge the request is sampled
    cur_addr_c  = (state_q == IDLE) ? bus.addr_i    : addr_q;
    cur_we_c    = (state_q == IDLE) ? bus.data_we_i : we_q;
    cur_wdata_c = (state_q == IDLE) ? bus.data_i    : wdata_q;

    enter_ack_c = (state_d == ACK);
    in_range_c  = ({1'b0, cur_addr_c} < (ADDR_W + 1)'(DEPTH));
    mem_en_c    = rst & enter_ack_c & in_range_c;
    ack_d       = enter_ack_c;

    zero_d = zero_q;
    if (enter_ack_c && !cur_we_c) begin
      zero_d = !in_range_c;
    end

`ifdef DMEM_MAILBOX_INT_EN
    int_req_d = int_req_q;
    if (bus.int_ack_i) begin
      int_req_d = 1'b0;
    end
    if (enter_ack_c && cur_we_c && (cur_addr_c == MBOX_ADDR)) begin
      int_req_d = 1'b1;
    end
`else
    int_req_d = 1'b0;
`endif
  end

`ifndef DMEM_MAILBOX_INT_EN
  logic unused_mbox_c;
  assign unused_mbox_c = ^{bus.int_ack_i, MBOX_ADDR};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      ack_q     <= 1'b0;
      zero_q    <= 1'b1;
      int_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      ack_q     <= ack_d;
      zero_q    <= zero_d;
      int_req_q <= int_req_d;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (mem_en_c),
    .we    (cur_we_c),
    .idx   (IDX_W'(cur_addr_c)),
    .wdata (cur_wdata_c),
    .rdata (rdata_c)
  );

  // Read data is forced to zero after reset and after an out-of-range read
  assign bus.data_o     = zero_q ? '0 : rdata_c;
  assign bus.data_ack_o = ack_q;
  assign bus.int_req_o  = int_req_q;

endmodule
